seven_segment_mux: RTL
======================

// Module: seven_segment_mux
// PURPOSE
//  N-digit time-multiplexed seven-segment driver for the frequency counter display.
//  Captures a packed BCD count on load and scans one digit per refresh slot at a programmable rate.
//  Updates the displayed frame only at frame boundaries, so a scan never tears.
//  Supports leading-zero blanking, per-digit decimal point, anti-ghost blanking and output polarity.
// PARAMETERS
//  NUM_DIGITS     4     digits scanned, >=2
//  REFRESH_DIV    1000  clk cycles per digit slot, >=2
//  BLANK_CYCLES   1     cycles at slot start with all digits off (anti-ghost), < REFRESH_DIV
//  BLANK_LEADING  1     1 = suppress leading zeros (digit 0 is never suppressed)
//  SEG_ACTIVE_LOW 0     1 = invert segments and dp (common anode)
//  DIG_ACTIVE_LOW 0     1 = invert digit_en
// PORTS
//  clk          in   1               system clock
//  reset_n      in   1               reset: asynchronous, active-low
//  load         in   1               capture counts/dp_in this edge
//  counts       in   4*NUM_DIGITS    packed BCD; [3:0] = units (digit 0)
//  dp_in        in   NUM_DIGITS      decimal point per digit
//  segments     out  7               {g,f,e,d,c,b,a}, registered
//  dp           out  1               decimal point of the scanned digit, registered
//  digit_en     out  NUM_DIGITS      one-hot digit select, registered
//  frame_sync   out  1               1-cycle pulse when the display buffer updates
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (reset_n=0, immediate):
//   - prescaler=0, scan index=0
//   - shadow, display buffer and dp regs = 0; pending=0
//   - segments/dp = off at configured polarity; digit_en all inactive; frame_sync=0
//  Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = terminal count.
//   - On tick, the scan index advances and wraps NUM_DIGITS-1 -> 0.
//  Frame boundary = tick while index==NUM_DIGITS-1.
//  load: shadow <= {counts,dp_in} and pending <= 1. A later load before the boundary overwrites the shadow (last wins).
//  At a frame boundary:
//   - pending=1: display <= shadow; pending <= 0; frame_sync=1 on the next cycle.
//   - load in the same cycle as the boundary: display takes the live counts/dp_in (bypass), not the stale shadow; pending <= 0.
//   - pending=0: no update and no frame_sync.
//  Outputs are registered from the index and display buffer.
//   - digit_en, segments and dp change on the same edge. Latency from index change to outputs = 1 cycle.
//   - When the prescaler is < BLANK_CYCLES: digit_en all inactive and segments off.
//  Decode 0-9 to standard patterns (0=0111111, 1=0000110, 7=0000111, 8=1111111, 9=1100111).
//   - Codes 10-15 give all segments off, and dp is still driven.
//  Leading-zero blanking (BLANK_LEADING=1):
//   - Digit i>0 is blanked when display digits i..NUM_DIGITS-1 are all zero. Blanked = segments off, dp still shown.
//   - digit_en still pulses, so the scan timing is unchanged.
//  Mid-operation reset clears pending: a captured but undisplayed value is lost.
// STRUCTURE
//  Package seven_segment_pkg: SEG_0..SEG_9 and SEG_OFF constants, function bcd_to_seg(logic [3:0]).
//  Sub-module seven_segment_decoder: combinational BCD -> 7 segments. Polarity is applied in the top.
//  Top: prescaler, scan index, shadow/pending, display buffer, blank mask, output registers.
// TESTING
//  Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-high unless noted.
//  1. Reset released, no load -> digit_en cycles 0001,0010,0100,1000 (3 active cycles per slot, 1 off).
//     Only digit 0 shows SEG_0; digits 1-3 are blank.
//  2. load counts=16'h1234 mid-frame -> no change until the boundary, then frame_sync one cycle later.
//     Next frame shows 4,3,2,1 on digits 0-3.
//  3. Two loads (16'h0042, then 16'h0099) in one frame -> only 99 is displayed; digits 2-3 blanked.
//  4. load at the exact boundary cycle with counts=16'h0007 -> display updates that boundary; digit 0=0000111.
//  5. counts=16'h00A5, dp_in=4'b0010 -> digit 1 segments off with dp=1.
//  6. reset_n low mid-slot after a load -> outputs off asynchronously. After release, pending=0 and digit 0 shows 0.
//     Repeat with SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 -> all outputs inverted.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared constants and helpers for the seven-segment display path.
//   SEG_0..SEG_9 : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark
//   bcd_to_seg() : BCD digit to active-high pattern; codes 10-15 give SEG_OFF
// -----------------------------------------------------------------------------
package seven_segment_pkg;

    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1100111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_decoder
// Combinational BCD to seven-segment decode, always active-high; the top
// applies the board polarity.
//   bcd : input BCD digit (10-15 decode to all segments off)
//   seg : segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup shared with the package helper.
    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seven_segment_mux.sv
// -----------------------------------------------------------------------------
// seven_segment_mux
// Time-multiplexed N-digit seven-segment driver. A loaded count is held in a
// shadow register and copied to the display buffer only at a frame boundary
// (last slot's terminal count), so one scan never mixes two values.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   load       : capture counts/dp_in on this edge
//   counts     : packed BCD, [3:0] = digit 0 (units)
//   dp_in      : decimal point per digit
//   segments   : {g,f,e,d,c,b,a} of the scanned digit, registered
//   dp         : decimal point of the scanned digit, registered
//   digit_en   : one-hot digit select, registered
//   frame_sync : one-cycle pulse after the display buffer updates
// -----------------------------------------------------------------------------
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 1,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] counts,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_sync
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic          DIG_INV   = (DIG_ACTIVE_LOW != 0);

    logic [PW-1:0]           prescaler_r;
    logic [IW-1:0]           index_r;
    logic                    tick_s;
    logic                    boundary_s;
    logic [4*NUM_DIGITS-1:0] shadow_counts_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic                    pending_r;
    logic [4*NUM_DIGITS-1:0] disp_counts_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic                    frame_sync_r;
    logic [NUM_DIGITS-1:0]   lead_blank_s;
    logic                    run_zero_s;
    logic [3:0]              cur_bcd_s;
    logic                    cur_dp_s;
    logic [NUM_DIGITS-1:0]   dig_onehot_s;
    logic [6:0]              dec_seg_s;
    logic                    blank_win_s;
    logic [6:0]              seg_nxt_s;
    logic                    dp_nxt_s;
    logic [NUM_DIGITS-1:0]   en_nxt_s;
    logic [6:0]              segments_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   digit_en_r;

    assign tick_s      = (prescaler_r == PRE_LAST);
    assign boundary_s  = tick_s && (index_r == IDX_LAST);
    assign blank_win_s = (prescaler_r < BLANK_LIM);
    assign cur_bcd_s   = disp_counts_r[{index_r, 2'b00} +: 4];
    assign cur_dp_s    = disp_dp_r[index_r];

    // Slot prescaler: counts 0..REFRESH_DIV-1 and wraps on the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_r <= '0;
        end else if (tick_s) begin
            prescaler_r <= '0;
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
        end
    end

    // Scan index: advances once per slot, wrapping after the last digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_r <= '0;
        end else if (tick_s) begin
            index_r <= (index_r == IDX_LAST) ? '0 : index_r + IW'(1);
        end
    end

    // Shadow capture and frame-boundary transfer into the display buffer.
    // A load coinciding with the boundary bypasses the shadow so the newest
    // value is shown immediately rather than a stale one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_counts_r <= '0;
            shadow_dp_r     <= '0;
            pending_r       <= 1'b0;
            disp_counts_r   <= '0;
            disp_dp_r       <= '0;
            frame_sync_r    <= 1'b0;
        end else begin
            frame_sync_r <= 1'b0;
            if (load) begin
                shadow_counts_r <= counts;
                shadow_dp_r     <= dp_in;
            end
            if (boundary_s) begin
                if (load) begin
                    disp_counts_r <= counts;
                    disp_dp_r     <= dp_in;
                    frame_sync_r  <= 1'b1;
                end else if (pending_r) begin
                    disp_counts_r <= shadow_counts_r;
                    disp_dp_r     <= shadow_dp_r;
                    frame_sync_r  <= 1'b1;
                end
                pending_r <= 1'b0;
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and every higher digit are zero.
    always_comb begin
        lead_blank_s = '0;
        run_zero_s   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero_s      = run_zero_s & (disp_counts_r[4*i +: 4] == 4'd0);
            lead_blank_s[i] = run_zero_s & (BLANK_LEADING != 0);
        end
    end

    // One-hot select for the digit being scanned.
    always_comb begin
        dig_onehot_s          = '0;
        dig_onehot_s[index_r] = 1'b1;
    end

    seven_segment_decoder u_decoder (
        .bcd (cur_bcd_s),
        .seg (dec_seg_s)
    );

    // Next output values in active-high form; the anti-ghost window darkens everything.
    always_comb begin
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b0;
        en_nxt_s  = '0;
        if (blank_win_s) begin
            seg_nxt_s = SEG_OFF;
            dp_nxt_s  = 1'b0;
            en_nxt_s  = '0;
        end else begin
            en_nxt_s = dig_onehot_s;
            dp_nxt_s = cur_dp_s;
            if (lead_blank_s[index_r]) begin
                seg_nxt_s = SEG_OFF;
            end else begin
                seg_nxt_s = dec_seg_s;
            end
        end
    end

    // Output registers with board polarity applied; reset drives everything inactive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            segments_r <= {7{SEG_INV}};
            dp_r       <= SEG_INV;
            digit_en_r <= {NUM_DIGITS{DIG_INV}};
        end else begin
            segments_r <= seg_nxt_s ^ {7{SEG_INV}};
            dp_r       <= dp_nxt_s ^ SEG_INV;
            digit_en_r <= en_nxt_s ^ {NUM_DIGITS{DIG_INV}};
        end
    end

    assign segments   = segments_r;
    assign dp         = dp_r;
    assign digit_en   = digit_en_r;
    assign frame_sync = frame_sync_r;

endmodule
